// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared widths, state encoding and tuning constants for the dds_ii tuning controller
package dds_pkg;

  localparam int PHASE_W = 25;

  // 7.074 MHz phase increment at a 62.5 MHz sample clock
  localparam logic [PHASE_W-1:0] PHASE_7074K = 25'd3797825;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SETTLE = 2'd2,
    DWELL  = 2'd3
  } state_t;

endpackage

// File: rtl/dds_chan_table.sv
// rtl/dds_chan_table.sv - per-channel phase increment table, one sync write port, one comb read port
module dds_chan_table #(
  parameter int PHASE_W = 25,
  parameter int NUM_CH  = 8,
  parameter int CH_W    = $clog2(NUM_CH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [CH_W-1:0]    waddr,
  input  logic [PHASE_W-1:0] wdata,
  input  logic [CH_W-1:0]    raddr,
  output logic [PHASE_W-1:0] rdata
);

  logic [PHASE_W-1:0] mem [NUM_CH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Combinational read sees the pre-write contents, so a same-cycle load gets the old entry
  assign rdata = mem[raddr];

endmodule

// File: rtl/dds_tune_ctrl.sv
// rtl/dds_tune_ctrl.sv - single-tune / channel-scan controller driving dds_ii phase_i and reporting lock
module dds_tune_ctrl #(
  parameter int  PHASE_W    = dds_pkg::PHASE_W,
  parameter int  NUM_CH     = 8,
  parameter int  DWELL_W    = 24,
  parameter int  SETTLE_CYC = 16,
  localparam int CH_W       = $clog2(NUM_CH)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cfg_we_i,
  input  logic [CH_W-1:0]    cfg_addr_i,
  input  logic [PHASE_W-1:0] cfg_data_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [CH_W-1:0]    cmd_ch_i,
  input  logic               cmd_scan_i,
  input  logic [CH_W-1:0]    cmd_last_i,
  input  logic [DWELL_W-1:0] cmd_dwell_i,
  input  logic               stop_i,
  input  logic               dds_valid_i,
  output logic [PHASE_W-1:0] phase_o,
  output logic               phase_valid_o,
  output logic               locked_o,
  output logic               busy_o,
  output logic [CH_W-1:0]    cur_ch_o
);

  import dds_pkg::*;

  localparam int                 SET_W      = $clog2(SETTLE_CYC + 1);
  localparam logic [SET_W-1:0]   SETTLE_MAX = SET_W'(SETTLE_CYC);
  localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);
  localparam logic [CH_W-1:0]    CH_ONE     = CH_W'(1);

  state_t state_q, state_d;

  logic [CH_W-1:0]    start_q, last_q, cur_q;
  logic               scan_q;
  logic [DWELL_W-1:0] dwell_q, dwell_cnt_q;
  logic [SET_W-1:0]   settle_cnt_q;
  logic [PHASE_W-1:0] phase_q;
  logic               pv_q, locked_q, busy_q;

  logic [CH_W-1:0]    next_ch, rd_addr;
  logic [PHASE_W-1:0] rd_data;
  logic               accept, do_stop, dwell_exp;
  logic               do_load, do_lock;

  assign cmd_ready_o = (state_q == IDLE) & ~stop_i;
  assign accept      = cmd_valid_i & cmd_ready_o;
  assign do_stop     = stop_i & (state_q != IDLE);
  assign next_ch     = (cur_q == last_q) ? start_q : cur_q + CH_ONE;
  assign dwell_exp   = (dwell_cnt_q <= DWELL_ONE);
  assign rd_addr     = (state_q == IDLE) ? cmd_ch_i : next_ch;

  dds_chan_table #(
    .PHASE_W (PHASE_W),
    .NUM_CH  (NUM_CH),
    .CH_W    (CH_W)
  ) u_table (
    .clk   (clk_i),
    .rst   (rst_i),
    .we    (cfg_we_i),
    .waddr (cfg_addr_i),
    .wdata (cfg_data_i),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    do_load = 1'b0;
    do_lock = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          do_load = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: state_d = SETTLE;
      SETTLE: begin
        if (settle_cnt_q == SETTLE_MAX) begin
          do_lock = 1'b1;
          state_d = scan_q ? DWELL : IDLE;
        end
      end
      DWELL: begin
        if (dwell_exp) begin
          do_load = 1'b1;
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over any settle completion or dwell expiry in the same cycle
    if (do_stop) begin
      state_d = IDLE;
      do_load = 1'b0;
      do_lock = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      start_q      <= '0;
      last_q       <= '0;
      scan_q       <= 1'b0;
      dwell_q      <= '0;
      dwell_cnt_q  <= '0;
      settle_cnt_q <= '0;
      phase_q      <= '0;
      pv_q         <= 1'b0;
      locked_q     <= 1'b0;
      busy_q       <= 1'b0;
      cur_q        <= '0;
    end else begin
      pv_q   <= do_load;
      busy_q <= (state_d != IDLE);

      if (accept) begin
        start_q <= cmd_ch_i;
        last_q  <= cmd_last_i;
        scan_q  <= cmd_scan_i;
        dwell_q <= (cmd_dwell_i == '0) ? DWELL_ONE : cmd_dwell_i;
      end

      if (do_load) begin
        phase_q  <= rd_data;
        cur_q    <= rd_addr;
        locked_q <= 1'b0;
      end

      if (state_q == LOAD) begin
        settle_cnt_q <= '0;
      end else if (state_q == SETTLE) begin
        if (!dds_valid_i) begin
          settle_cnt_q <= '0;
        end else if (settle_cnt_q != SETTLE_MAX) begin
          settle_cnt_q <= settle_cnt_q + 1'b1;
        end
      end

      // The lock cycle itself is the first cycle of the dwell period
      if (do_lock) begin
        locked_q    <= 1'b1;
        dwell_cnt_q <= dwell_q - DWELL_ONE;
      end else if (state_q == DWELL && !dwell_exp) begin
        dwell_cnt_q <= dwell_cnt_q - DWELL_ONE;
      end

      if (do_stop) begin
        locked_q <= 1'b0;
      end
    end
  end

  assign phase_o       = phase_q;
  assign phase_valid_o = pv_q;
  assign locked_o      = locked_q;
  assign busy_o        = busy_q;
  assign cur_ch_o      = cur_q;

endmodule

// File: tb/tb_dds_tune_ctrl.sv
// tb/tb_dds_tune_ctrl.sv - scoreboard bench for dds_tune_ctrl with a channel-list scan model
module tb_dds_tune_ctrl;
  import dds_pkg::*;

  localparam int NUM_CH     = 8;
  localparam int CH_W       = 3;
  localparam int DWELL_W    = 24;
  localparam int SETTLE_CYC = 16;
  localparam int PW         = dds_pkg::PHASE_W;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cfg_we = 1'b0;
  logic [CH_W-1:0]    cfg_addr = '0;
  logic [PW-1:0]      cfg_data = '0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [CH_W-1:0]    cmd_ch = '0;
  logic               cmd_scan = 1'b0;
  logic [CH_W-1:0]    cmd_last = '0;
  logic [DWELL_W-1:0] cmd_dwell = '0;
  logic               stop = 1'b0;
  logic               dds_valid = 1'b1;
  logic [PW-1:0]      phase;
  logic               phase_valid;
  logic               locked;
  logic               busy;
  logic [CH_W-1:0]    cur_ch;

  dds_tune_ctrl #(
    .PHASE_W    (PW),
    .NUM_CH     (NUM_CH),
    .DWELL_W    (DWELL_W),
    .SETTLE_CYC (SETTLE_CYC)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cfg_we_i      (cfg_we),
    .cfg_addr_i    (cfg_addr),
    .cfg_data_i    (cfg_data),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_ch_i      (cmd_ch),
    .cmd_scan_i    (cmd_scan),
    .cmd_last_i    (cmd_last),
    .cmd_dwell_i   (cmd_dwell),
    .stop_i        (stop),
    .dds_valid_i   (dds_valid),
    .phase_o       (phase),
    .phase_valid_o (phase_valid),
    .locked_o      (locked),
    .busy_o        (busy),
    .cur_ch_o      (cur_ch)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            t;
    logic [PW-1:0] ph;
    int            ch;
  } pulse_t;

  pulse_t        pq[$];
  int            lq[$];
  logic [PW-1:0] tbl[NUM_CH];
  int            n_chk = 0;
  int            n_fail = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every phase pulse and every lock rise must match the head of its queue
  pulse_t mp;
  int     ml;
  logic   prev_lock = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (phase_valid) begin
        if (pq.size() == 0) begin
          check("unexpected_pulse", 64'd1, 64'd0);
        end else begin
          mp = pq.pop_front();
          check("pulse_time", cyc, mp.t);
          check("pulse_phase", phase, mp.ph);
          check("pulse_ch", cur_ch, mp.ch);
        end
      end
      if (locked && !prev_lock) begin
        if (lq.size() == 0) begin
          check("unexpected_lock", 64'd1, 64'd0);
        end else begin
          ml = lq.pop_front();
          check("lock_time", cyc, ml);
        end
      end
    end
    prev_lock = locked;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic wr(input int a, input logic [PW-1:0] d);
    cfg_we   = 1'b1;
    cfg_addr = CH_W'(a);
    cfg_data = d;
    tick();
    cfg_we   = 1'b0;
    tbl[a]   = d;
  endtask

  task automatic issue(input int ch, input bit scan, input int last, input int dwell);
    cmd_valid = 1'b1;
    cmd_ch    = CH_W'(ch);
    cmd_scan  = scan;
    cmd_last  = CH_W'(last);
    cmd_dwell = DWELL_W'(dwell);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Scan model: the visited channels form a list start..last (wrapping mod NUM_CH), repeated
  task automatic run_scan(input int st, input int la, input int dw, input int np,
                          input int off, input int cidx, input logic [PW-1:0] cval);
    int            lst[$];
    int            per, t0, ch, cch;
    logic [PW-1:0] ph, last_ph;
    pulse_t        p;
    ch = st;
    lst.push_back(ch);
    while (ch != la) begin
      ch = (ch + 1) % NUM_CH;
      lst.push_back(ch);
    end
    per     = 1 + SETTLE_CYC + dw;
    t0      = cyc + 1;
    cch     = lst[cidx % lst.size()];
    last_ph = '0;
    for (int k = 0; k < np; k++) begin
      ch   = lst[k % lst.size()];
      ph   = (k > cidx && ch == cch) ? cval : tbl[ch];
      p.t  = t0 + k * per;
      p.ph = ph;
      p.ch = ch;
      pq.push_back(p);
      last_ph = ph;
      if (k < np - 1 || off > SETTLE_CYC + 2) lq.push_back(t0 + k * per + SETTLE_CYC + 2);
    end
    issue(st, 1'b1, la, dw);
    wait_until(t0 + cidx * per - 1);
    cfg_we   = 1'b1;
    cfg_addr = CH_W'(cch);
    cfg_data = cval;
    tick();
    cfg_we   = 1'b0;
    tbl[cch] = cval;
    wait_until(t0 + (np - 1) * per + off - 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    @(negedge clk);
    check("scan_stop_busy", busy, 64'd0);
    check("scan_stop_locked", locked, 64'd0);
    check("scan_stop_phase_hold", phase, last_ph);
    check("scan_stop_ready", cmd_ready, 64'd1);
    wait_until(cyc + per + 4);
    check("scan_pulses_drained", pq.size(), 64'd0);
    check("scan_locks_drained", lq.size(), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    pulse_t p;
    for (int i = 0; i < NUM_CH; i++) tbl[i] = '0;

    // Reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_phase", phase, 64'd0);
    check("rst_phase_valid", phase_valid, 64'd0);
    check("rst_locked", locked, 64'd0);
    check("rst_busy", busy, 64'd0);
    check("rst_cur_ch", cur_ch, 64'd0);
    check("rst_cmd_ready", cmd_ready, 64'd1);

    // Single tune to channel 3
    wr(3, PHASE_7074K);
    t = cyc + 1;
    p.t = t; p.ph = PHASE_7074K; p.ch = 3;
    pq.push_back(p);
    lq.push_back(t + SETTLE_CYC + 2);
    issue(3, 1'b0, 3, 0);
    wait_until(t + SETTLE_CYC + 1);
    @(negedge clk);
    check("single_busy_before_lock", busy, 64'd1);
    wait_until(t + SETTLE_CYC + 2);
    @(negedge clk);
    check("single_locked", locked, 64'd1);
    check("single_busy_after_lock", busy, 64'd0);
    check("single_ready_after_lock", cmd_ready, 64'd1);

    // Settle glitch: one invalid cycle after ten valid ones
    t = cyc + 1;
    p.t = t; p.ph = PHASE_7074K; p.ch = 3;
    pq.push_back(p);
    lq.push_back(t + 29);
    issue(3, 1'b0, 3, 0);
    wait_until(t + 11);
    dds_valid = 1'b0;
    tick();
    dds_valid = 1'b1;
    wait_until(t + 28);
    @(negedge clk);
    check("glitch_no_early_lock", locked, 64'd0);
    wait_until(t + 31);
    check("glitch_lock_seen", lq.size(), 64'd0);

    // Stop during SETTLE
    t = cyc + 1;
    p.t = t; p.ph = PHASE_7074K; p.ch = 3;
    pq.push_back(p);
    issue(3, 1'b0, 3, 0);
    wait_until(t + 8);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    @(negedge clk);
    check("stop_busy", busy, 64'd0);
    check("stop_locked", locked, 64'd0);
    check("stop_phase_hold", phase, PHASE_7074K);
    check("stop_ready", cmd_ready, 64'd1);
    wait_until(t + 30);
    @(negedge clk);
    check("stop_no_late_lock", locked, 64'd0);
    check("stop_no_extra_pulse", pq.size(), 64'd0);

    // Command together with stop in IDLE is refused
    stop      = 1'b1;
    cmd_valid = 1'b1;
    cmd_ch    = 3'd3;
    cmd_scan  = 1'b0;
    @(negedge clk);
    check("idle_stop_ready", cmd_ready, 64'd0);
    tick();
    cmd_valid = 1'b0;
    stop      = 1'b0;
    @(negedge clk);
    check("idle_stop_busy", busy, 64'd0);

    // Two-channel scan, table[2] rewritten on the same edge as a ch2 load
    wr(1, 25'd100);
    wr(2, 25'd200);
    run_scan(1, 2, 100, 6, 50, 3, 25'd999);

    // Randomized scans, including wrap-around and single-channel ranges
    for (int r = 0; r < 4; r++) begin
      int st, la, dw, np, off, cidx;
      for (int c = 0; c < NUM_CH; c++) wr(c, PW'($urandom));
      st   = $urandom_range(0, NUM_CH - 1);
      la   = (r == 0) ? st : $urandom_range(0, NUM_CH - 1);
      dw   = $urandom_range(2, 30);
      np   = $urandom_range(3, 10);
      off  = $urandom_range(1, SETTLE_CYC + dw);
      cidx = $urandom_range(1, np - 2);
      run_scan(st, la, dw, np, off, cidx, PW'($urandom));
    end

    tick();
    check("final_pulses_drained", pq.size(), 64'd0);
    check("final_locks_drained", lq.size(), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
